axi_write_response_channel: RTL and testbench

AXI_WRITE_RESPONSE_CHANNEL -- requirements
Module: axi_write_response_channel

---
 rtl/axi_write_response_channel_if.sv | 31 +++
 rtl/axi_write_response_channel.sv | 154 +++++++++++++++
 tb/tb_axi_write_response_channel.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_write_response_channel_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_write_response_channel_if
// Description : AXI write-response (B) channel bundle. The master modport is
//               the side that accepts responses (drives BREADY); the slave
//               modport is the responder (drives BID/BRESP/BVALID).
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_write_response_channel_if #(
    parameter int ID_WIDTH = 4
);
    logic [ID_WIDTH-1:0] BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        input  BID,
        input  BRESP,
        input  BVALID,
        output BREADY
    );

    modport slave (
        output BID,
        output BRESP,
        output BVALID,
        input  BREADY
    );
endinterface
`default_nettype wire

// File: rtl/axi_write_response_channel.sv
`default_nettype none
// ============================================================================
// Module      : axi_write_response_channel
// Description : Waits for the AXI write response matching a requested ID,
//               captures BRESP, flags ID mismatches and reports completion.
//               Optional watchdog enabled by defining AXI_WRESP_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_write_response_channel #(
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic                clk,
    input  wire logic                resetn,
    input  wire logic                go,
    input  wire logic [ID_WIDTH-1:0] transaction_ID,
    axi_write_response_channel_if.master b_if,
    output logic                     done,
    output logic                     resp_ok,
    output logic [1:0]               resp_code,
    output logic                     id_mismatch,
    output logic                     timeout,
    output logic [2:0]               current_state_out
);

    typedef enum logic [2:0] {
        S_RESET    = 3'b000,
        S_IDLE     = 3'b001,
        S_WAITING  = 3'b010,
        S_COMPLETE = 3'b011
    } state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] exp_id_q, exp_id_d;
    logic                resp_ok_q, resp_ok_d;
    logic [1:0]          resp_code_q, resp_code_d;
    logic                id_mismatch_q, id_mismatch_d;

    logic w_handshake;
    logic w_id_mismatch;

    // TIMEOUT_CYCLES outside 1..65535 cannot be represented by the watchdog.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_bad
    end

`ifdef AXI_WRESP_TIMEOUT_EN
    localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
`endif

    assign w_handshake   = b_if.BVALID && (state_q == S_WAITING);
    assign w_id_mismatch = (b_if.BID != exp_id_q);

    // Next-state and result-capture decode
    always_comb begin
        state_d       = S_RESET;
        exp_id_d      = exp_id_q;
        resp_ok_d     = resp_ok_q;
        resp_code_d   = resp_code_q;
        id_mismatch_d = id_mismatch_q;
`ifdef AXI_WRESP_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_d     = timeout_q;
`endif
        case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE: begin
                state_d = S_IDLE;
                if (go) begin
                    exp_id_d      = transaction_ID;
                    resp_ok_d     = 1'b0;
                    resp_code_d   = 2'b00;
                    id_mismatch_d = 1'b0;
`ifdef AXI_WRESP_TIMEOUT_EN
                    cnt_d         = 16'd0;
                    timeout_d     = 1'b0;
`endif
                    state_d       = S_WAITING;
                end
            end
            S_WAITING: begin
                state_d = S_WAITING;
                if (w_handshake) begin
                    // A handshake always wins over a same-edge watchdog expiry
                    resp_code_d   = b_if.BRESP;
                    id_mismatch_d = w_id_mismatch;
                    resp_ok_d     = !b_if.BRESP[1] && !w_id_mismatch;
                    state_d       = S_COMPLETE;
                end
`ifdef AXI_WRESP_TIMEOUT_EN
                else if (cnt_q == C_TIMEOUT_LAST) begin
                    timeout_d     = 1'b1;
                    resp_ok_d     = 1'b0;
                    resp_code_d   = 2'b00;
                    id_mismatch_d = 1'b0;
                    state_d       = S_COMPLETE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            S_COMPLETE: state_d = go ? S_COMPLETE : S_IDLE;
            default:    state_d = S_RESET;
        endcase
    end

    // State and result registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_RESET;
            exp_id_q      <= '0;
            resp_ok_q     <= 1'b0;
            resp_code_q   <= 2'b00;
            id_mismatch_q <= 1'b0;
`ifdef AXI_WRESP_TIMEOUT_EN
            cnt_q         <= 16'd0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            exp_id_q      <= exp_id_d;
            resp_ok_q     <= resp_ok_d;
            resp_code_q   <= resp_code_d;
            id_mismatch_q <= id_mismatch_d;
`ifdef AXI_WRESP_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    // Debug encoding: legal states pass through, anything else reads 111
    always_comb begin
        current_state_out = 3'b111;
        case (state_q)
            S_RESET, S_IDLE, S_WAITING, S_COMPLETE: current_state_out = state_q;
            default: current_state_out = 3'b111;
        endcase
    end

    assign b_if.BREADY = (state_q == S_WAITING);
    assign done        = (state_q == S_COMPLETE);
    assign resp_ok     = resp_ok_q;
    assign resp_code   = resp_code_q;
    assign id_mismatch = id_mismatch_q;
`ifdef AXI_WRESP_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_write_response_channel.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_write_response_channel
// Description : Directed scoreboard bench for axi_write_response_channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_write_response_channel;

    localparam int ID_WIDTH = 4;

    typedef struct packed {
        logic       ok;
        logic [1:0] code;
        logic       mis;
        logic       to;
    } exp_t;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                go = 1'b0;
    logic [ID_WIDTH-1:0] transaction_ID = '0;
    logic                done, resp_ok, id_mismatch, timeout;
    logic [1:0]          resp_code;
    logic [2:0]          current_state_out;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    logic done_prev = 1'b0;

    axi_write_response_channel_if #(.ID_WIDTH(ID_WIDTH)) bif ();

    axi_write_response_channel #(
        .ID_WIDTH       (ID_WIDTH),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .go                (go),
        .transaction_ID    (transaction_ID),
        .b_if              (bif.master),
        .done              (done),
        .resp_ok           (resp_ok),
        .resp_code         (resp_code),
        .id_mismatch       (id_mismatch),
        .timeout           (timeout),
        .current_state_out (current_state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: compare results on the first cycle of every done
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_ok",     {31'd0, resp_ok},     {31'd0, e.ok});
                chk("resp_code",   {30'd0, resp_code},   {30'd0, e.code});
                chk("id_mismatch", {31'd0, id_mismatch}, {31'd0, e.mis});
                chk("timeout",     {31'd0, timeout},     {31'd0, e.to});
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept go, hold BVALID off for `wait_cyc` WAITING edges, then respond.
    task automatic run_txn(input logic [3:0] id, input logic [3:0] bid, input logic [1:0] bresp,
                           input int wait_cyc, input exp_t e);
        exp_q.push_back(e);
        go = 1'b1;
        transaction_ID = id;
        tick();
        @(negedge clk);
        chk("bready_after_go", {31'd0, bif.BREADY}, 32'd1);
        chk("state_waiting", {29'd0, current_state_out}, 32'd2);
        go = 1'b0;  // go level is ignored in WAITING
        for (int i = 0; i < wait_cyc; i++) tick();
        go = 1'b1;
        bif.BID = bid;
        bif.BRESP = bresp;
        bif.BVALID = 1'b1;
        tick();
        bif.BVALID = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (!done && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("done_within_bound", {31'd0, done}, 32'd1);
        end
        tick();  // go still high: COMPLETE must hold
        @(negedge clk);
        chk("complete_held", {29'd0, current_state_out}, 32'd3);
        go = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_after_go_drop", {29'd0, current_state_out}, 32'd1);
        chk("result_held_idle", {31'd0, resp_ok}, {31'd0, e.ok});
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        bif.BID = '0;
        bif.BRESP = 2'b00;
        bif.BVALID = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state",  {29'd0, current_state_out}, 32'd0);
        chk("rst_bready", {31'd0, bif.BREADY}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_results", {27'd0, resp_ok, resp_code, id_mismatch, timeout}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_after_reset", {29'd0, current_state_out}, 32'd1);

        // OKAY, matching ID
        run_txn(4'd5, 4'd5, 2'b00, 3, '{ok:1'b1, code:2'b00, mis:1'b0, to:1'b0});
        // SLVERR, matching ID
        run_txn(4'd3, 4'd3, 2'b10, 1, '{ok:1'b0, code:2'b10, mis:1'b0, to:1'b0});
        // OKAY, wrong ID
        run_txn(4'd7, 4'd2, 2'b00, 0, '{ok:1'b0, code:2'b00, mis:1'b1, to:1'b0});
        // EXOKAY, matching ID
        run_txn(4'hF, 4'hF, 2'b01, 2, '{ok:1'b1, code:2'b01, mis:1'b0, to:1'b0});
        // DECERR, wrong ID
        run_txn(4'h0, 4'h8, 2'b11, 0, '{ok:1'b0, code:2'b11, mis:1'b1, to:1'b0});

`ifdef AXI_WRESP_TIMEOUT_EN
        // Watchdog expiry after 8 WAITING cycles
        exp_q.push_back('{ok:1'b0, code:2'b00, mis:1'b0, to:1'b1});
        go = 1'b1;
        transaction_ID = 4'd6;
        tick();
        for (int i = 0; i < 7; i++) tick();
        @(negedge clk);
        chk("wd_still_waiting", {29'd0, current_state_out}, 32'd2);
        tick();
        @(negedge clk);
        chk("wd_complete", {29'd0, current_state_out}, 32'd3);
        go = 1'b0;
        tick();
        tick();
        // Handshake on the 8th WAITING edge wins over expiry
        exp_q.push_back('{ok:1'b1, code:2'b00, mis:1'b0, to:1'b0});
        go = 1'b1;
        transaction_ID = 4'd4;
        tick();
        for (int i = 0; i < 7; i++) tick();
        bif.BID = 4'd4;
        bif.BRESP = 2'b00;
        bif.BVALID = 1'b1;
        tick();
        bif.BVALID = 1'b0;
        @(negedge clk);
        chk("wd_edge_hs_done", {31'd0, done}, 32'd1);
        go = 1'b0;
        tick();
        tick();
`else
        // Without the watchdog, WAITING persists indefinitely
        go = 1'b1;
        transaction_ID = 4'd6;
        tick();
        for (int i = 0; i < 40; i++) tick();
        @(negedge clk);
        chk("no_wd_still_waiting", {29'd0, current_state_out}, 32'd2);
        chk("no_wd_timeout_zero", {31'd0, timeout}, 32'd0);
        go = 1'b0;
`endif

        // Reset mid-WAITING: abandon with no done
        if (current_state_out != 3'd2) begin
            go = 1'b1;
            transaction_ID = 4'd9;
            tick();
        end
        @(negedge clk);
        chk("pre_reset_waiting", {29'd0, current_state_out}, 32'd2);
        go = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        chk("async_rst_state",  {29'd0, current_state_out}, 32'd0);
        chk("async_rst_bready", {31'd0, bif.BREADY}, 32'd0);
        chk("async_rst_done",   {31'd0, done}, 32'd0);
        chk("async_rst_results", {27'd0, resp_ok, resp_code, id_mismatch, timeout}, 32'd0);
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("post_release_reset", {29'd0, current_state_out}, 32'd0);
        tick();
        @(negedge clk);
        chk("post_release_idle", {29'd0, current_state_out}, 32'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("pending_expect", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
